// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity and frame-bit constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling bit timer: counts edges within a bit, takes three mid-bit samples
// and majority-votes them into sampled_bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt_reg;
  logic [2:0]            samples_reg;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  take_sample;

  assign half        = prescale >> 1;
  assign last_edge   = prescale - ONE;
  assign take_sample = run && ((edge_cnt_reg == half - TWO) ||
                               (edge_cnt_reg == half - ONE) ||
                               (edge_cnt_reg == half));

  // The counter is held at 0 while idle so a frame always starts at edge_cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_reg <= '0;
      samples_reg  <= 3'b111;
    end else begin
      if (!run || edge_cnt_reg == last_edge) begin
        edge_cnt_reg <= '0;
      end else begin
        edge_cnt_reg <= edge_cnt_reg + ONE;
      end
      if (take_sample) begin
        samples_reg <= {samples_reg[1:0], rx_in};
      end
    end
  end

  assign edge_cnt    = edge_cnt_reg;
  assign sampled_bit = majority3(samples_reg);
  assign bit_end     = run && (edge_cnt_reg == last_edge);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity check and registered
// one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

  rx_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_sh_reg, data_sh_next;
  logic                  par_flag_reg, par_flag_next;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  par_en_reg, par_typ_reg;
  logic                  latch_cfg;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  par_err_reg, par_err_next;
  logic                  stp_err_reg, stp_err_next;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  sampled_bit;
  logic                  bit_end;
  logic                  run;
  logic [PRESCALE_W-1:0] valid_point;
  logic                  expected_par;

  assign run          = (state_reg != IDLE);
  assign valid_point  = (prescale_reg >> 1) + ONE;
  assign expected_par = (par_typ_reg == PAR_EVEN) ? ^data_sh_reg : ~^data_sh_reg;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .run        (run),
    .rx_in      (RX_IN),
    .prescale   (prescale_reg),
    .edge_cnt   (edge_cnt),
    .sampled_bit(sampled_bit),
    .bit_end    (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      data_sh_reg    <= '0;
      par_flag_reg   <= 1'b0;
      prescale_reg   <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      data_sh_reg    <= data_sh_next;
      par_flag_reg   <= par_flag_next;
      p_data_reg     <= p_data_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
      if (latch_cfg) begin
        prescale_reg <= Prescale;
        par_en_reg   <= PAR_EN;
        par_typ_reg  <= PAR_TYP;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    data_sh_next    = data_sh_reg;
    par_flag_next   = par_flag_reg;
    latch_cfg       = 1'b0;
    p_data_next     = p_data_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_IN == START_BIT) begin
          state_next    = START;
          latch_cfg     = 1'b1;
          par_flag_next = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = (sampled_bit == START_BIT) ? DATA : IDLE;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        // Shift as soon as the vote is settled; the bit counter advances at bit end.
        if (edge_cnt == valid_point) begin
          data_sh_next = {sampled_bit, data_sh_reg[DATA_WIDTH-1:1]};
        end
        if (bit_end) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_flag_next = (sampled_bit != expected_par);
          state_next    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (sampled_bit != STOP_BIT) begin
            stp_err_next = 1'b1;
          end else if (par_flag_reg) begin
            par_err_next = 1'b1;
          end else begin
            data_valid_next = 1'b1;
            p_data_next     = data_sh_reg;
          end
          par_flag_next = 1'b0;
          // A low line at the stop-bit end is already the next start bit.
          state_next    = (RX_IN == START_BIT) ? START : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign P_DATA     = p_data_reg;
  assign Data_valid = data_valid_reg;
  assign Par_err    = par_err_reg;
  assign Stp_err    = stp_err_reg;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's UART transmitter (FSM + serializer + parity + mux path). It oversamples the asynchronous serial line RX_IN and recovers start, data, optional parity and stop bits. It presents the byte on P_DATA with a one-cycle Data_valid pulse, or raises a parity or stop error pulse instead. Frame format matches the TX side: start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_W, 6, width of the Prescale input
- CLK  input  1  receiver clock (oversampling clock, Prescale × baud)
- RST  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line; idles high; already synchronized upstream
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- Prescale  input  PRESCALE_W  oversampling ratio P; legal values 8, 16, 32; others are undefined
- P_DATA  output  DATA_WIDTH  last good byte received
- Data_valid  output  1  one-cycle pulse when P_DATA is updated
- Par_err  output  1  one-cycle pulse on a parity mismatch
- Stp_err  output  1  one-cycle pulse when the stop bit is sampled as 0

## Operation
- States:
  - IDLE: while RX_IN=1, stay in IDLE.
  - IDLE → START: at the first edge that samples RX_IN=0, move to START with edge_cnt=0. Latch Prescale, PAR_EN and PAR_TYP for the whole frame.
  - START: if the start bit is voted 1, it is a glitch: return to IDLE at the end of the bit, with no output pulse. If it is voted 0, go to DATA.
  - DATA: shift in DATA_WIDTH bits, LSB first, with bit_cnt counting 0..DATA_WIDTH-1. Then go to PARITY if PAR_EN, otherwise to STOP.
  - PARITY: compare the voted bit with the expected parity and store a mismatch flag. Expected parity is ^data for even, ~^data for odd. Go to STOP.
  - STOP: at the end of the bit, issue exactly one of Data_valid, Par_err or Stp_err. Then go to START if RX_IN=0 in that cycle (back-to-back frames), else to IDLE.
- Bit timing: edge_cnt runs 0..P-1 per bit and wraps at P-1; the bit ends at edge_cnt = P-1.
- Sampling: three samples are taken at edge_cnt = P/2-2, P/2-1 and P/2. The bit value is the majority of the three and is valid from edge_cnt = P/2+1.
- Priority at the end of STOP: Stp_err beats Par_err, and Par_err beats Data_valid. Only one output pulses per frame.
- On any error, P_DATA is not updated and keeps its previous value.
- Input changes mid-frame: changes to Prescale, PAR_EN or PAR_TYP are ignored until the next IDLE → START transition.

## Timing
- Reset values: P_DATA=0, Data_valid=0, Par_err=0, Stp_err=0; state IDLE, all counters 0.
- Reset mid-frame: the frame is aborted and no pulse is issued. After reset release the block waits in IDLE for a falling RX_IN.
- Frame length: N = 2 + DATA_WIDTH + PAR_EN bits.
- Latency: let k be the edge that first samples RX_IN=0 in IDLE. The output pulse is registered and is high for the cycle following edge k + N·P.
- Pulse width: all pulse outputs are high for exactly one cycle. P_DATA changes on the same edge that raises Data_valid.
- Back-to-back frames: zero idle bits between frames are supported with no lost frame.

## Structure
- Shared package uart_pkg:
  - state encoding for the receiver;
  - PAR_EVEN = 0 and PAR_ODD = 1, the same constants the TX parity calculator uses;
  - frame bit constants START_BIT = 0 and STOP_BIT = 1.
- Sub-module uart_rx_sampler: edge counter, three-sample shift and majority vote. It outputs edge_cnt, sampled_bit and bit_end.
- The top level holds the FSM, the deserializer shift register, the parity checker and the output registers.

## Test plan
- P=8, PAR_EN=1, PAR_TYP=0: send 0xA5 with parity 0 and stop 1. Required: P_DATA=0xA5 and Data_valid pulse at k+88+1; Par_err=0, Stp_err=0.
- P=16, PAR_EN=0: send 0x81. Required: Data_valid at k+160+1 and P_DATA=0x81.
- P=8, even parity: send 0x3C with parity bit 1. Required: Par_err pulse only; Data_valid=0 and P_DATA keeps its previous value 0x81.
- P=8: send 0x55 with stop bit 0. Required: Stp_err pulse only. A 2-cycle low glitch on RX_IN gives no pulse, and the block is back in IDLE within P cycles.
- P=32, odd parity: send 0x11 then 0x22 back-to-back with no idle gap. Required: two Data_valid pulses exactly 11·32 cycles apart, with P_DATA 0x11 then 0x22.
- Assert RST in the middle of the data bits of 0xF0. Required: all outputs are 0 immediately and no pulse follows. A subsequent 0x0F frame is received correctly.
